note_frame_sequencer: RTL

Per-beat frame controller for the falling-notes display. On each accepted `beat` it does three things in order. It erases every lit note cell through the plotter. It pulses the notes register to shift down one row. It then redraws every lit cell. Note positions on screen therefore advance one row per eighth note. It sits between the rate driver, the notes register and the plotter, and replaces ad-hoc sequencing in the top-level control path.

---
 rtl/note_frame_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/note_frame_sequencer.sv
// note_frame_sequencer: per-beat frame controller for the falling-notes display.
// Each accepted beat erases every lit cell, shifts the notes register one row,
// then redraws every lit cell through the plotter handshake.
module note_frame_sequencer #(
    parameter int unsigned LANES  = 5,
    parameter int unsigned ROWS   = 8,
    parameter int unsigned ROW_W  = 3,
    parameter int unsigned LANE_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beat,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic [LANES-1:0]  row_notes,
    input  logic              plot_done,
    output logic [ROW_W-1:0]  row_addr,
    output logic [LANE_W-1:0] lane,
    output logic              draw_req,
    output logic              draw_erase,
    output logic              shift_en,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ERASE_SCAN = 3'd1,
        S_ERASE_WAIT = 3'd2,
        S_SHIFT      = 3'd3,
        S_DRAW_SCAN  = 3'd4,
        S_DRAW_WAIT  = 3'd5
    } state_t;

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_addr_q, row_addr_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              draw_req_q, draw_req_d;
    logic              draw_erase_q, draw_erase_d;
    logic              shift_en_q, shift_en_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic              cell_lit;
    logic              cell_last;
    logic              erase_phase;
    logic [ROW_W-1:0]  row_next;
    logic [LANE_W-1:0] lane_next;
    state_t            phase_exit;

    // Current-cell status and the row-major successor of the scan position.
    always_comb begin
        cell_lit    = row_notes[lane_q];
        cell_last   = (row_addr_q == ROW_LAST) && (lane_q == LANE_LAST);
        erase_phase = (state_q == S_ERASE_SCAN) || (state_q == S_ERASE_WAIT);
        phase_exit  = erase_phase ? S_SHIFT : S_IDLE;
        if (lane_q == LANE_LAST) begin
            lane_next = '0;
            row_next  = row_addr_q + ROW_W'(1);
        end else begin
            lane_next = lane_q + LANE_W'(1);
            row_next  = row_addr_q;
        end
    end

    // Next-state and next-output logic; every output is a function of the next state.
    always_comb begin
        state_d    = state_q;
        row_addr_d = row_addr_q;
        lane_d     = lane_q;
        overrun_d  = overrun_q | (beat & (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (beat && start && !pause && !stop) begin
                    state_d    = S_ERASE_SCAN;
                    row_addr_d = '0;
                    lane_d     = '0;
                end
            end
            S_ERASE_SCAN, S_DRAW_SCAN: begin
                if (stop) begin
                    state_d    = S_IDLE;
                    row_addr_d = '0;
                    lane_d     = '0;
                end else if (cell_lit) begin
                    state_d = erase_phase ? S_ERASE_WAIT : S_DRAW_WAIT;
                end else if (cell_last) begin
                    state_d    = phase_exit;
                    row_addr_d = '0;
                    lane_d     = '0;
                end else begin
                    row_addr_d = row_next;
                    lane_d     = lane_next;
                end
            end
            S_ERASE_WAIT, S_DRAW_WAIT: begin
                if (plot_done) begin
                    if (cell_last) begin
                        state_d    = phase_exit;
                        row_addr_d = '0;
                        lane_d     = '0;
                    end else begin
                        state_d    = erase_phase ? S_ERASE_SCAN : S_DRAW_SCAN;
                        row_addr_d = row_next;
                        lane_d     = lane_next;
                    end
                end
            end
            S_SHIFT: begin
                state_d    = stop ? S_IDLE : S_DRAW_SCAN;
                row_addr_d = '0;
                lane_d     = '0;
            end
            default: begin
                state_d    = S_IDLE;
                row_addr_d = '0;
                lane_d     = '0;
            end
        endcase

        busy_d       = (state_d != S_IDLE);
        draw_req_d   = (state_d == S_ERASE_WAIT) || (state_d == S_DRAW_WAIT);
        draw_erase_d = (state_d == S_ERASE_WAIT);
        shift_en_d   = (state_d == S_SHIFT);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_addr_q   <= '0;
            lane_q       <= '0;
            draw_req_q   <= 1'b0;
            draw_erase_q <= 1'b0;
            shift_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_addr_q   <= row_addr_d;
            lane_q       <= lane_d;
            draw_req_q   <= draw_req_d;
            draw_erase_q <= draw_erase_d;
            shift_en_q   <= shift_en_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign row_addr   = row_addr_q;
    assign lane       = lane_q;
    assign draw_req   = draw_req_q;
    assign draw_erase = draw_erase_q;
    assign shift_en   = shift_en_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
